// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command parser: parser state encoding,
// the packet sync byte, error cause codes and the hard payload length limit.
// Optional feature macro used elsewhere in this slice: UART_CMD_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         MAX_LEN_LIMIT = 4;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CSUM    = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_FRAME   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    // Running checksum is a plain 8-bit sum that wraps on overflow.
    function automatic logic [7:0] csumAdd(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser_if
// Bundles the byte-receive side and the command/error output side of the
// UART command parser.
//   rx_frame/rx_done/frame_error : received byte, strobe, parity error
//   cmd_valid/cmd_ready          : decoded command handshake
//   cmd_code/cmd_len/cmd_data    : decoded command contents
//   err_pulse/err_code           : one-cycle error strobe and latched cause
// Modports: master = byte source / command consumer, slave = parser.
// -----------------------------------------------------------------------------
interface uart_cmd_parser_if;

    logic [7:0]  rx_frame;
    logic        rx_done;
    logic        frame_error;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        err_pulse;
    logic [2:0]  err_code;

    modport master (
        output rx_frame, rx_done, frame_error, cmd_ready,
        input  cmd_valid, cmd_code, cmd_len, cmd_data, err_pulse, err_code
    );

    modport slave (
        input  rx_frame, rx_done, frame_error, cmd_ready,
        output cmd_valid, cmd_code, cmd_len, cmd_data, err_pulse, err_code
    );

endinterface

// File: rtl/uart_byte_timer.sv
// -----------------------------------------------------------------------------
// uart_byte_timer
// Inter-byte timeout counter. Counts clock cycles while enabled and flags
// expiry when the count reaches CYCLES-1. Only built with UART_CMD_TIMEOUT_EN.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : restart the count (a byte arrived)
//   i_enable   : count only while a packet is in progress
//   o_expire   : count has reached CYCLES-1 while enabled
// -----------------------------------------------------------------------------
module uart_byte_timer #(
    parameter int CYCLES = 125_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] r_count;

    assign o_expire = i_enable && (r_count == W'(CYCLES - 1));

    // Dropping enable also restarts the count, so every packet starts fresh
    // and the counter saturates at the expiry value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (!o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Parses UART byte packets of the form SYNC(0xA5), CMD, LEN, LEN payload
// bytes, CSUM into a command with a valid/ready handshake, and reports
// protocol errors as one-cycle pulses with a latched cause code.
// Ports:
//   clk      : system clock, rising edge
//   reset_p  : asynchronous active-high reset
//   bus      : uart_cmd_parser_if.slave (byte input, command and error output)
// Parameters: CLK_FREQUENCE (Hz), TIMEOUT_CYCLES (inter-byte timeout),
//   MAX_LEN (payload limit 1..4).
// Optional feature: define UART_CMD_TIMEOUT_EN to abandon a packet whose
//   bytes stop arriving; without it the parser waits indefinitely.
// -----------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQUENCE  = 125_000_000,
    parameter int TIMEOUT_CYCLES = 125_000,
    parameter int MAX_LEN        = 4
) (
    input  logic clk,
    input  logic reset_p,
    uart_cmd_parser_if.slave bus
);

    // Reject configurations the datapath cannot represent.
    if (MAX_LEN < 1 || MAX_LEN > MAX_LEN_LIMIT || TIMEOUT_CYCLES < 2 || CLK_FREQUENCE < 1) begin : g_badParam
        $error("uart_cmd_parser: illegal parameter value");
    end

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_cmd;
    logic [2:0]  r_len;
    logic [2:0]  r_idx;
    logic [31:0] r_data;
    logic [7:0]  r_sum;
    logic [7:0]  r_outCode;
    logic [2:0]  r_outLen;
    logic [31:0] r_outData;
    logic        r_errPulse;
    logic [2:0]  r_errCode;

    logic        w_startPkt;
    logic        w_loadCmd;
    logic        w_loadLen;
    logic        w_loadData;
    logic        w_commit;
    logic        w_errFire;
    logic [2:0]  w_errCause;
    logic        w_syncByte;
    logic        w_expire;

    assign w_syncByte = bus.rx_done && !bus.frame_error && (bus.rx_frame == SYNC_BYTE);

`ifdef UART_CMD_TIMEOUT_EN
    logic w_timerEn;

    assign w_timerEn = (r_state == ST_CMD) || (r_state == ST_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM);

    uart_byte_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (reset_p),
        .i_clear  (bus.rx_done),
        .i_enable (w_timerEn),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Next state and datapath control. A sync byte inside a packet is plain
    // data; only IDLE (or HOLD with a simultaneous handshake) looks for it.
    always_comb begin
        w_nextState = r_state;
        w_startPkt  = 1'b0;
        w_loadCmd   = 1'b0;
        w_loadLen   = 1'b0;
        w_loadData  = 1'b0;
        w_commit    = 1'b0;
        w_errFire   = 1'b0;
        w_errCause  = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_syncByte) begin
                    w_nextState = ST_CMD;
                    w_startPkt  = 1'b1;
                end
            end
            ST_CMD: begin
                if (bus.rx_done) begin
                    if (bus.frame_error) begin
                        w_nextState = ST_IDLE;
                        w_errFire   = 1'b1;
                        w_errCause  = ERR_FRAME;
                    end else begin
                        w_nextState = ST_LEN;
                        w_loadCmd   = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (bus.rx_done) begin
                    if (bus.frame_error) begin
                        w_nextState = ST_IDLE;
                        w_errFire   = 1'b1;
                        w_errCause  = ERR_FRAME;
                    end else if (bus.rx_frame == 8'd0) begin
                        w_nextState = ST_CSUM;
                        w_loadLen   = 1'b1;
                    end else if (int'(bus.rx_frame) <= MAX_LEN) begin
                        w_nextState = ST_DATA;
                        w_loadLen   = 1'b1;
                    end else begin
                        w_nextState = ST_IDLE;
                        w_errFire   = 1'b1;
                        w_errCause  = ERR_LEN;
                    end
                end
            end
            ST_DATA: begin
                if (bus.rx_done) begin
                    if (bus.frame_error) begin
                        w_nextState = ST_IDLE;
                        w_errFire   = 1'b1;
                        w_errCause  = ERR_FRAME;
                    end else begin
                        w_loadData = 1'b1;
                        if (r_idx + 3'd1 == r_len) begin
                            w_nextState = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (bus.rx_done) begin
                    if (bus.frame_error) begin
                        w_nextState = ST_IDLE;
                        w_errFire   = 1'b1;
                        w_errCause  = ERR_FRAME;
                    end else if (bus.rx_frame == r_sum) begin
                        w_nextState = ST_HOLD;
                        w_commit    = 1'b1;
                    end else begin
                        w_nextState = ST_IDLE;
                        w_errFire   = 1'b1;
                        w_errCause  = ERR_CSUM;
                    end
                end
            end
            ST_HOLD: begin
                // With the handshake completing, the byte is treated as an
                // IDLE byte; otherwise it has nowhere to go and is dropped.
                if (bus.cmd_ready) begin
                    w_nextState = ST_IDLE;
                    if (w_syncByte) begin
                        w_nextState = ST_CMD;
                        w_startPkt  = 1'b1;
                    end
                end else if (bus.rx_done) begin
                    w_errFire  = 1'b1;
                    w_errCause = ERR_OVERRUN;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        // A byte arriving in the expiry cycle still counts, so it wins.
        if (w_expire && !bus.rx_done) begin
            w_nextState = ST_IDLE;
            w_errFire   = 1'b1;
            w_errCause  = ERR_TIMEOUT;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Packet assembly: header, payload and running checksum. Payload is
    // cleared at packet start so unused upper bytes read as zero.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_cmd  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_data <= '0;
            r_sum  <= '0;
        end else begin
            if (w_startPkt) begin
                r_idx  <= '0;
                r_data <= '0;
                r_sum  <= '0;
            end
            if (w_loadCmd) begin
                r_cmd <= bus.rx_frame;
                r_sum <= csumAdd(r_sum, bus.rx_frame);
            end
            if (w_loadLen) begin
                r_len <= bus.rx_frame[2:0];
                r_sum <= csumAdd(r_sum, bus.rx_frame);
            end
            if (w_loadData) begin
                case (r_idx[1:0])
                    2'd0:    r_data[7:0]   <= bus.rx_frame;
                    2'd1:    r_data[15:8]  <= bus.rx_frame;
                    2'd2:    r_data[23:16] <= bus.rx_frame;
                    default: r_data[31:24] <= bus.rx_frame;
                endcase
                r_idx <= r_idx + 3'd1;
                r_sum <= csumAdd(r_sum, bus.rx_frame);
            end
        end
    end

    // Output command registers are only written on a good checksum, so they
    // stay stable throughout HOLD even if a new packet starts right after.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_outCode <= '0;
            r_outLen  <= '0;
            r_outData <= '0;
        end else if (w_commit) begin
            r_outCode <= r_cmd;
            r_outLen  <= r_len;
            r_outData <= r_data;
        end
    end

    // Error strobe lasts one cycle; the cause code is held until the next error.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_errPulse <= 1'b0;
            r_errCode  <= ERR_NONE;
        end else begin
            r_errPulse <= w_errFire;
            if (w_errFire) begin
                r_errCode <= w_errCause;
            end
        end
    end

    assign bus.cmd_valid = (r_state == ST_HOLD);
    assign bus.cmd_code  = r_outCode;
    assign bus.cmd_len   = r_outLen;
    assign bus.cmd_data  = r_outData;
    assign bus.err_pulse = r_errPulse;
    assign bus.err_code  = r_errCode;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Scoreboard bench for uart_cmd_parser: expected commands and error codes are
// queued as bytes are driven and compared when the parser produces them.
// Honours UART_CMD_TIMEOUT_EN (DUT built with TIMEOUT_CYCLES=100).
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    typedef struct {
        logic [7:0]  code;
        logic [2:0]  len;
        logic [31:0] data;
    } cmd_t;

    logic clk;
    logic reset_p;
    int   checkCount;
    int   failCount;
    cmd_t cmdQ[$];
    logic [2:0] errQ[$];

    uart_cmd_parser_if ifc ();

    uart_cmd_parser #(
        .CLK_FREQUENCE  (125_000_000),
        .TIMEOUT_CYCLES (100),
        .MAX_LEN        (4)
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (ifc)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one byte for a single cycle; optionally raises cmd_ready in the
    // same cycle. Returns 1 time unit after the edge that captured the byte.
    task automatic applyStimulus(input logic [7:0] b, input logic fe, input logic readyToo);
        @(posedge clk);
        #1;
        ifc.rx_frame    = b;
        ifc.rx_done     = 1'b1;
        ifc.frame_error = fe;
        if (readyToo) ifc.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rx_done     = 1'b0;
        ifc.frame_error = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends a whole packet; the bench computes the checksum and queues the
    // expected command (or a checksum error when corrupted).
    task automatic sendPacket(input logic [7:0] code, input int len, input logic [31:0] data, input bit corrupt);
        logic [7:0]  sum;
        logic [31:0] expData;
        cmd_t        exp;
        sum     = code + 8'(len);
        expData = '0;
        applyStimulus(SYNC_BYTE, 1'b0, 1'b0);
        applyStimulus(code, 1'b0, 1'b0);
        applyStimulus(8'(len), 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            applyStimulus(data[8*i +: 8], 1'b0, 1'b0);
            sum = sum + data[8*i +: 8];
            expData[8*i +: 8] = data[8*i +: 8];
        end
        if (corrupt) begin
            errQ.push_back(ERR_CSUM);
            applyStimulus(sum + 8'd1, 1'b0, 1'b0);
            checkOutput("errLatency", {31'd0, ifc.err_pulse}, 32'd1);
        end else begin
            exp.code = code;
            exp.len  = 3'(len);
            exp.data = expData;
            cmdQ.push_back(exp);
            applyStimulus(sum, 1'b0, 1'b0);
            checkOutput("validLatency", {31'd0, ifc.cmd_valid}, 32'd1);
        end
        idleCycles(3);
    endtask

    // Monitor: compares accepted commands and error pulses against the queues.
    always @(negedge clk) begin
        if (!reset_p) begin
            if (ifc.cmd_valid && ifc.cmd_ready) begin
                if (cmdQ.size() == 0) begin
                    checkOutput("cmdUnexpected", {31'd0, ifc.cmd_valid}, 32'd0);
                end else begin
                    cmd_t exp;
                    exp = cmdQ.pop_front();
                    checkOutput("cmdCode", {24'd0, ifc.cmd_code}, {24'd0, exp.code});
                    checkOutput("cmdLen",  {29'd0, ifc.cmd_len},  {29'd0, exp.len});
                    checkOutput("cmdData", ifc.cmd_data, exp.data);
                end
            end
            if (ifc.err_pulse) begin
                if (errQ.size() == 0) begin
                    checkOutput("errUnexpected", {31'd0, ifc.err_pulse}, 32'd0);
                end else begin
                    logic [2:0] expErr;
                    expErr = errQ.pop_front();
                    checkOutput("errCode", {29'd0, ifc.err_code}, {29'd0, expErr});
                end
            end
        end
    end

    initial begin
        checkCount      = 0;
        failCount       = 0;
        reset_p         = 1'b1;
        ifc.rx_frame    = 8'h00;
        ifc.rx_done     = 1'b0;
        ifc.frame_error = 1'b0;
        ifc.cmd_ready   = 1'b1;
        idleCycles(3);
        #2;
        reset_p = 1'b0;
        idleCycles(2);

        // Reset state.
        checkOutput("rstValid",    {31'd0, ifc.cmd_valid}, 32'd0);
        checkOutput("rstCode",     {24'd0, ifc.cmd_code},  32'd0);
        checkOutput("rstLen",      {29'd0, ifc.cmd_len},   32'd0);
        checkOutput("rstData",     ifc.cmd_data,           32'd0);
        checkOutput("rstErrPulse", {31'd0, ifc.err_pulse}, 32'd0);
        checkOutput("rstErrCode",  {29'd0, ifc.err_code},  32'd0);

        // Basic packet, bad checksum then zero-length packet.
        sendPacket(8'h10, 2, 32'h0000_1234, 1'b0);
        sendPacket(8'h10, 2, 32'h0000_1234, 1'b1);
        checkOutput("errPulseOneCycle", {31'd0, ifc.err_pulse}, 32'd0);
        sendPacket(8'h20, 0, 32'h0, 1'b0);

        // Length too large, then a stray byte that must be ignored.
        applyStimulus(SYNC_BYTE, 1'b0, 1'b0);
        applyStimulus(8'h10, 1'b0, 1'b0);
        errQ.push_back(ERR_LEN);
        applyStimulus(8'h05, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(8'h34, 1'b0, 1'b0);
        idleCycles(2);

        // Frame error mid-packet; frame error and noise while idle.
        applyStimulus(SYNC_BYTE, 1'b0, 1'b0);
        errQ.push_back(ERR_FRAME);
        applyStimulus(8'h10, 1'b1, 1'b0);
        idleCycles(2);
        applyStimulus(SYNC_BYTE, 1'b1, 1'b0);
        applyStimulus(8'h77, 1'b0, 1'b0);
        idleCycles(2);

        // Sync byte values inside the packet are data, and full-length payload.
        sendPacket(SYNC_BYTE, 4, 32'hA5A5_A5A5, 1'b0);
        sendPacket(8'h3C, 1, 32'h0000_00A5, 1'b0);

        // Random packets.
        for (int n = 0; n < 6; n++) begin
            sendPacket(8'($urandom), int'($urandom_range(0, 4)), $urandom, 1'(n == 3));
        end

        // Consumer stalls: overrun while holding, then handshake with a
        // simultaneous sync byte that starts the next packet.
        ifc.cmd_ready = 1'b0;
        sendPacket(8'h42, 3, 32'h00C0_FFEE, 1'b0);
        errQ.push_back(ERR_OVERRUN);
        applyStimulus(8'h33, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("validHeld",   {31'd0, ifc.cmd_valid}, 32'd1);
        checkOutput("heldCode",    {24'd0, ifc.cmd_code},  32'h42);
        applyStimulus(SYNC_BYTE, 1'b0, 1'b1);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        cmdQ.push_back('{8'h20, 3'd0, 32'd0});
        applyStimulus(8'h20, 1'b0, 1'b0);
        idleCycles(3);

`ifdef UART_CMD_TIMEOUT_EN
        // Stalled packet is abandoned after the timeout.
        applyStimulus(SYNC_BYTE, 1'b0, 1'b0);
        errQ.push_back(ERR_TIMEOUT);
        applyStimulus(8'h10, 1'b0, 1'b0);
        idleCycles(105);
        checkOutput("timeoutIdle", {31'd0, ifc.cmd_valid}, 32'd0);
        sendPacket(8'h11, 1, 32'h0000_0022, 1'b0);
`else
        // Without the timeout, a stalled packet completes later.
        applyStimulus(SYNC_BYTE, 1'b0, 1'b0);
        applyStimulus(8'h10, 1'b0, 1'b0);
        idleCycles(150);
        applyStimulus(8'h00, 1'b0, 1'b0);
        cmdQ.push_back('{8'h10, 3'd0, 32'd0});
        applyStimulus(8'h10, 1'b0, 1'b0);
        checkOutput("noTimeoutValid", {31'd0, ifc.cmd_valid}, 32'd1);
        idleCycles(3);
`endif

        // Reset mid-packet clears everything; next packet still decodes.
        applyStimulus(SYNC_BYTE, 1'b0, 1'b0);
        applyStimulus(8'h10, 1'b0, 1'b0);
        #2;
        reset_p = 1'b1;
        #3;
        checkOutput("midRstValid",   {31'd0, ifc.cmd_valid}, 32'd0);
        checkOutput("midRstCode",    {24'd0, ifc.cmd_code},  32'd0);
        checkOutput("midRstLen",     {29'd0, ifc.cmd_len},   32'd0);
        checkOutput("midRstData",    ifc.cmd_data,           32'd0);
        checkOutput("midRstErrCode", {29'd0, ifc.err_code},  32'd0);
        idleCycles(2);
        reset_p = 1'b0;
        idleCycles(2);
        sendPacket(8'h10, 2, 32'h0000_1234, 1'b0);

        idleCycles(5);
        checkOutput("cmdQueueDrained", cmdQ.size(), 32'd0);
        checkOutput("errQueueDrained", errQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter CLK_FREQUENCE, default 125_000_000, meaning system clock in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 125_000, meaning inter-byte timeout in clk cycles (1 ms).
REQ-003 SHALL have parameter MAX_LEN, default 4, meaning max payload bytes; legal range 1..4.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_p  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_frame  input  8  received byte; valid only when rx_done=1.
REQ-007 SHALL have port rx_done  input  1  single-cycle byte-received strobe.
REQ-008 SHALL have port frame_error  input  1  parity error on the byte; sampled with rx_done.
REQ-009 SHALL have port cmd_valid  output  1  decoded command available.
REQ-010 SHALL have port cmd_ready  input  1  consumer accepts command.
REQ-011 SHALL have port cmd_code  output  8  command byte.
REQ-012 SHALL have port cmd_len  output  3  payload byte count, 0..MAX_LEN.
REQ-013 SHALL have port cmd_data  output  32  payload; first byte in [7:0], unused bytes zero.
REQ-014 SHALL have port err_pulse  output  1  one-cycle error strobe.
REQ-015 SHALL have port err_code  output  3  error cause, valid with err_pulse: 1 CSUM, 2 LEN, 3 FRAME, 4 TIMEOUT, 5 OVERRUN.

Function
REQ-016 SHALL implement packet format: SYNC(0xA5), CMD, LEN, LEN payload bytes, CSUM.
REQ-017 SHALL use states IDLE, CMD, LEN, DATA, CSUM, HOLD; advance only on rx_done.
REQ-018 IDLE: byte 0xA5 -> CMD; any other byte ignored, no error.
REQ-019 CMD -> LEN; LEN: value 0 -> CSUM, 1..MAX_LEN -> DATA, >MAX_LEN -> IDLE with err LEN.
REQ-020 DATA: store byte at index 0..LEN-1; after LEN-th byte -> CSUM.
REQ-021 Checksum SHALL be 8-bit wrapping sum of CMD, LEN and payload bytes; CSUM byte equal -> HOLD, else -> IDLE with err CSUM.
REQ-022 cmd_valid SHALL rise the cycle after rx_done of a correct CSUM byte; cmd_code/cmd_len/cmd_data stable while cmd_valid=1.
REQ-023 HOLD: cmd_valid=1 until cmd_ready=1, then -> IDLE, cmd_valid=0 next cycle.
REQ-024 rx_done in HOLD without cmd_ready: byte dropped, err OVERRUN, stay HOLD.
REQ-025 rx_done and cmd_ready same cycle in HOLD: handshake completes, byte processed as IDLE byte (0xA5 -> CMD).
REQ-026 frame_error=1 with rx_done in CMD/LEN/DATA/CSUM: packet discarded -> IDLE, err FRAME; in IDLE: byte ignored, no error.
REQ-027 err_pulse SHALL be exactly one cycle, asserted the cycle after the causing event; err_code holds last cause.
REQ-028 0xA5 inside CMD/LEN/DATA/CSUM SHALL be treated as data, not resync.

Reset
REQ-029 reset_p SHALL force state IDLE, cmd_valid=0, cmd_code=0, cmd_len=0, cmd_data=0, err_pulse=0, err_code=0, checksum and timer cleared, including mid-packet.

Configuration
REQ-030 With UART_CMD_TIMEOUT_EN defined, timer SHALL clear on each rx_done and count in CMD/LEN/DATA/CSUM; reaching TIMEOUT_CYCLES-1 -> IDLE, err TIMEOUT.
REQ-031 Without UART_CMD_TIMEOUT_EN, no timer logic SHALL exist; code 4 never issued; parser waits indefinitely.

Structure
REQ-032 Package uart_cmd_pkg SHALL hold state encoding, SYNC_BYTE=8'hA5, err code constants, MAX_LEN_LIMIT=4.
REQ-033 Timeout counter SHALL be sub-module uart_byte_timer (clear, enable, expire outputs), instantiated only under UART_CMD_TIMEOUT_EN.

Verification
REQ-034 A5 10 02 34 12 58 with cmd_ready=1 -> cmd_valid one cycle after last rx_done, cmd_code=10, cmd_len=2, cmd_data=0000_1234.
REQ-035 A5 10 02 34 12 59 -> no cmd_valid, err_pulse one cycle, err_code=1; then A5 20 00 20 -> cmd_code=20, cmd_len=0, cmd_data=0.
REQ-036 A5 10 05 -> err_code=2, state IDLE; following 34 ignored without error.
REQ-037 A5 10 with frame_error=1 on second byte -> err_code=3; cmd_ready=0 after valid packet plus extra byte -> err_code=5, cmd_valid stays 1.
REQ-038 UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: A5 10 then 100 idle cycles -> err_code=4; reset_p mid-packet -> all outputs zero, next valid packet decodes.
